// File: rtl/data_mem_responder_if.sv
// CPU-to-data-memory handshake: the CPU drives the request side, the responder
// drives read data, completion, stall and error back.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] data;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  data, ack, stall, err
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output data, ack, stall, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory for the MEM stage: captures one request, completes
// it after LATENCY cycles with a one-cycle ack, stalling the pipeline meanwhile.
//   state | meaning
//   IDLE  | waiting; a request is captured on the next edge
//   BUSY  | counting down towards the commit edge
//   DONE  | ack cycle; the held instruction is not re-accepted
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   data_q, data_d;
  logic          wr_q, wr_d;
  logic          errf_q, errf_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic          req;
  logic          req_err;
  logic          acc_go;
  logic          acc_wr;
  logic          acc_err;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;

  logic [31:0]   mem [DEPTH];

  assign req     = bus.MemRead | bus.MemWrite;
  assign req_err = (bus.Address[1:0] != 2'b00)
                || ({2'b00, bus.Address[31:2]} >= 32'(DEPTH))
                || (bus.MemRead && bus.MemWrite);
  assign acc_idx = acc_addr[AW+1:2];

  assign bus.stall = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign bus.data  = data_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    errf_d    = errf_q;
    acc_go    = 1'b0;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wr    = wr_q;
    acc_err   = errf_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.Address;
          wdata_d = bus.WriteData;
          wr_d    = bus.MemWrite;
          errf_d  = req_err;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Single-cycle latency commits on the capture edge itself.
            state_d   = DONE;
            acc_go    = 1'b1;
            acc_addr  = bus.Address;
            acc_wdata = bus.WriteData;
            acc_wr    = bus.MemWrite;
            acc_err   = req_err;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_go  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d  = acc_go;
    err_d  = acc_go && acc_err;
    data_d = data_q;
    if (acc_go) begin
      if (acc_err)     data_d = 32'h0;
      else if (!acc_wr) data_d = mem[acc_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      errf_q  <= 1'b0;
      data_q  <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      errf_q  <= errf_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; rst_i gating keeps a held request from writing during reset.
  always_ff @(posedge clk_i) begin
    if (acc_go && acc_wr && !acc_err && !rst_i) mem[acc_idx] <= acc_wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=3 and a LATENCY=1 instance, each checked
// every cycle against a request/completion timeline model plus literal expectations.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst, rd, wr, ack, stl, er;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] dat [2];

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();

  assign b0.MemRead = rd[0];  assign b0.MemWrite = wr[0];
  assign b0.Address = ad[0];  assign b0.WriteData = wd[0];
  assign b1.MemRead = rd[1];  assign b1.MemWrite = wr[1];
  assign b1.Address = ad[1];  assign b1.WriteData = wd[1];
  assign dat[0] = b0.data;  assign ack[0] = b0.ack;  assign stl[0] = b0.stall;  assign er[0] = b0.err;
  assign dat[1] = b1.data;  assign ack[1] = b1.ack;  assign stl[1] = b1.stall;  assign er[1] = b1.err;

  data_mem_responder #(.DEPTH(256), .LATENCY(3)) u_lat3 (.clk_i(clk), .rst_i(rst[0]), .bus(b0));
  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_lat1 (.clk_i(clk), .rst_i(rst[1]), .bus(b1));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Timeline model: a request seen while free completes LAT cycles later.
  int          lat [2] = '{3, 1};
  bit          infl [2];
  int          done_c [2];
  int          nfree [2];
  logic [31:0] m_ad [2];
  logic [31:0] m_wd [2];
  bit          m_wr [2];
  bit          m_er [2];
  logic [31:0] edata [2];
  logic [31:0] pend [2];
  logic [31:0] mm [2][256];
  bit          rq, e_ack, e_err, e_stl, acc;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rq = rd[d] | wr[d];
      acc = 1'b0;
      if (rst[d]) begin
        infl[d] = 1'b0;
        edata[d] = 32'h0;
        nfree[d] = cyc + 1;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_stl = rq;
      end else begin
        e_ack = infl[d] && (cyc == done_c[d]);
        e_err = e_ack && m_er[d];
        if (e_ack) begin
          edata[d] = pend[d];
          infl[d]  = 1'b0;
          nfree[d] = cyc + 1;
        end
        acc   = !infl[d] && (cyc >= nfree[d]) && rq;
        e_stl = acc || infl[d];
      end
      chk($sformatf("ack[%0d]", d), ack[d], e_ack);
      chk($sformatf("err[%0d]", d), er[d], e_err);
      chk($sformatf("stall[%0d]", d), stl[d], e_stl);
      chk($sformatf("data[%0d]", d), dat[d], edata[d]);
      if (acc) begin
        m_ad[d]   = ad[d];
        m_wd[d]   = wd[d];
        m_wr[d]   = wr[d];
        m_er[d]   = (ad[d][1:0] != 2'b00) || (ad[d][31:2] >= 30'd256) || (rd[d] && wr[d]);
        done_c[d] = cyc + lat[d];
        infl[d]   = 1'b1;
      end
      if (infl[d] && cyc == done_c[d] - 1) begin
        if (m_er[d])      pend[d] = 32'h0;
        else if (m_wr[d]) begin
          mm[d][m_ad[d][9:2]] = m_wd[d];
          pend[d] = edata[d];
        end else pend[d] = mm[d][m_ad[d][9:2]];
      end
    end
  end

  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wdat, input int hold,
                        output int t0, output int tack, output int scnt,
                        output logic [31:0] dout, output logic eout);
    bit got;
    rd[d] = r;  wr[d] = w;  ad[d] = a;  wd[d] = wdat;
    t0 = cyc;  tack = -1;  scnt = 0;  dout = 32'h0;  eout = 1'b0;  got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (stl[d]) scnt++;
      if (ack[d]) begin
        got = 1'b1;  tack = cyc;  dout = dat[d];  eout = er[d];
      end
      @(posedge clk); #1;
      if (hold > 0 && k + 1 == hold) begin rd[d] = 1'b0; wr[d] = 1'b0; end
    end
    rd[d] = 1'b0;  wr[d] = 1'b0;
    chk("ack_timeout", 32'(got), 32'd1);
  endtask

  int          t0, ta, sc, t0b, tab;
  logic [31:0] dv, dvb;
  logic        ev, evb;

  initial begin
    rst = 2'b11;  rd = 2'b00;  wr = 2'b00;
    ad[0] = 0;  ad[1] = 0;  wd[0] = 0;  wd[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 2'b00;
    @(posedge clk); #1;
    chk("reset_data", dat[0], 32'h0);
    chk("reset_ack", 32'(ack[0]), 32'h0);

    // LATENCY=3 instance
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, t0, ta, sc, dv, ev);
    chk("wr_lat", ta - t0, 3);  chk("wr_stall_cycles", sc, 3);  chk("wr_err", 32'(ev), 0);
    access(0, 1, 0, 32'h10, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("rd_lat", ta - t0, 3);  chk("rd_data", dv, 32'hDEADBEEF);
    access(0, 1, 0, 32'h13, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("misalign_err", 32'(ev), 1);  chk("misalign_data", dv, 32'h0);
    access(0, 1, 0, 32'h400, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("range_err", 32'(ev), 1);  chk("range_data", dv, 32'h0);
    access(0, 1, 0, 32'h10, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("word4_kept", dv, 32'hDEADBEEF);
    access(0, 0, 1, 32'h8, 32'h55, 0, t0, ta, sc, dv, ev);
    access(0, 1, 1, 32'h8, 32'h99, 0, t0, ta, sc, dv, ev);
    chk("rdwr_err", 32'(ev), 1);  chk("rdwr_data", dv, 32'h0);
    access(0, 1, 0, 32'h8, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("word2_kept", dv, 32'h55);
    access(0, 0, 1, 32'h20, 32'hAAAA, 1, t0, ta, sc, dv, ev);
    chk("drop_lat", ta - t0, 3);
    access(0, 1, 0, 32'h20, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("drop_data", dv, 32'hAAAA);
    access(0, 0, 1, 32'h24, 32'h0, 0, t0, ta, sc, dv, ev);

    // Reset pulse one cycle into a write aborts it.
    rd[0] = 1'b0;  wr[0] = 1'b1;  ad[0] = 32'h24;  wd[0] = 32'h1234;
    @(posedge clk); #1;
    wr[0] = 1'b0;  rst[0] = 1'b1;
    #1;
    chk("rst_mid_data", dat[0], 32'h0);
    chk("rst_mid_stall", 32'(stl[0]), 32'h0);
    @(negedge clk); #2 rst[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    access(0, 1, 0, 32'h24, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("rst_abort_data", dv, 32'h0);

    // LATENCY=1 instance, back-to-back reads
    access(1, 0, 1, 32'h0, 32'h11, 0, t0, ta, sc, dv, ev);
    chk("l1_wr_lat", ta - t0, 1);
    access(1, 0, 1, 32'h4, 32'h22, 0, t0, ta, sc, dv, ev);
    access(1, 1, 0, 32'h0, 32'h0, 0, t0, ta, sc, dv, ev);
    access(1, 1, 0, 32'h4, 32'h0, 0, t0b, tab, sc, dvb, evb);
    chk("b2b_ack1", ta - t0, 1);
    chk("b2b_ack2", tab - t0, 3);
    chk("b2b_data1", dv, 32'h11);
    chk("b2b_data2", dvb, 32'h22);
    access(1, 1, 0, 32'h13, 32'h0, 0, t0, ta, sc, dv, ev);
    chk("l1_misalign_err", 32'(ev), 1);  chk("l1_misalign_data", dv, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
